// File: rtl/adder_tree_operand_loader.sv
// ---------------------------------------------------------------------------
// adder_tree_operand_loader
//
// Staging stage in front of the 64-input FP32 adder tree. Operands arrive
// over a narrow valid/ready stream, LANES 32-bit words per beat, and are
// packed into a fill buffer. Once the buffer is complete and the tree is
// free (or is finishing on this very edge), the buffer is copied into the
// held output register and a one-cycle ExE_start pulse is issued. The next
// vector can load while the tree is working on the current one.
//
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : beat present on in_data
//   in_ready    : loader accepts a beat this cycle (= fill buffer not full)
//   in_data     : beat, in_data[32*LANES-1 -: 32] is the earliest word
//   flush       : discard a partial or full fill buffer
//   inputs      : operand bus to the tree, first word at inputs[NI*32-1 -: 32]
//   ExE_start   : one-cycle start pulse to the tree
//   ExE_finish  : completion pulse from the tree
//   busy        : vector issued, finish not yet seen
//   vec_count   : vectors issued since reset, wraps modulo 2^CW
//   err         : sticky, ExE_finish seen while not busy
// ---------------------------------------------------------------------------
module adder_tree_operand_loader #(
    parameter int NI    = 64,
    parameter int LANES = 4,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_data,
    input  logic                  flush,
    output logic [NI*32-1:0]      inputs,
    output logic                  ExE_start,
    input  logic                  ExE_finish,
    output logic                  busy,
    output logic [CW-1:0]         vec_count,
    output logic                  err
);

    localparam int BEATS = NI / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = 32 * LANES;

    logic [BW-1:0]      cnt_p0;
    logic               full_p0;
    logic [NI*32-1:0]   fill_p0;

    logic accept;
    logic last_beat;
    logic issue;

    assign in_ready  = !full_p0;
    // A beat offered on a flush edge is dropped.
    assign accept    = in_valid && in_ready && !flush;
    assign last_beat = (cnt_p0 == BW'(BEATS - 1));
    // A finish on the same edge frees the tree for the waiting vector.
    assign issue     = full_p0 && (!busy || ExE_finish);

    // ---- stage p0: fill buffer collection ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0  <= '0;
            full_p0 <= 1'b0;
        end else if (flush) begin
            cnt_p0  <= '0;
            full_p0 <= 1'b0;
        end else if (issue) begin
            full_p0 <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                cnt_p0  <= '0;
                full_p0 <= 1'b1;
            end else begin
                cnt_p0  <= cnt_p0 + BW'(1);
            end
        end
    end

    // Beat b lands as one contiguous slice: word j of beat b is fill word
    // b*LANES+j, and fill word 0 is the most significant word.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_p0 == BW'(b)) begin
                    fill_p0[NI*32-1-b*BEAT_BITS -: BEAT_BITS] <= in_data;
                end
            end
        end
    end

    // ---- stage p1: held operand register and tree handshake ----
    always_ff @(posedge clk) begin
        if (rst) begin
            inputs    <= '0;
            ExE_start <= 1'b0;
            busy      <= 1'b0;
            vec_count <= '0;
            err       <= 1'b0;
        end else begin
            ExE_start <= issue;
            if (issue) begin
                inputs    <= fill_p0;
                busy      <= 1'b1;
                vec_count <= vec_count + CW'(1);
            end else if (ExE_finish) begin
                busy      <= 1'b0;
            end
            if (ExE_finish && !busy) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
module tb_adder_tree_operand_loader;

    localparam int NI    = 64;
    localparam int LANES = 4;
    localparam int CW    = 16;
    localparam int BEATS = NI / LANES;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [32*LANES-1:0]  in_data = '0;
    logic                 flush = 1'b0;
    logic [NI*32-1:0]     inputs;
    logic                 ExE_start;
    logic                 ExE_finish = 1'b0;
    logic                 busy;
    logic [CW-1:0]        vec_count;
    logic                 err;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;

    adder_tree_operand_loader #(.NI(NI), .LANES(LANES), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .inputs(inputs),
        .ExE_start(ExE_start), .ExE_finish(ExE_finish), .busy(busy),
        .vec_count(vec_count), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ExE_start) starts++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NI*32-1:0] exp_vec(input logic [31:0] base);
        logic [NI*32-1:0] v;
        for (int k = 0; k < NI; k++) v[NI*32-1-32*k -: 32] = base + 32'(k) + 32'd1;
        return v;
    endfunction

    task automatic chkv(input string tag, input logic [NI*32-1:0] obs, input logic [NI*32-1:0] exp);
        int bad;
        bad = -1;
        vectors++;
        for (int k = NI - 1; k >= 0; k--)
            if (obs[NI*32-1-32*k -: 32] !== exp[NI*32-1-32*k -: 32]) bad = k;
        assert (obs === exp) else begin
            miscompares++;
            if (bad < 0) bad = 0;
            $error("FAIL %s word %0d observed=%08h expected=%08h", tag, bad,
                   obs[NI*32-1-32*bad -: 32], exp[NI*32-1-32*bad -: 32]);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends nbeats beats of the vector whose words are base+1, base+2, ...
    task automatic send(input logic [31:0] base, input int nbeats, input bit gaps);
        int t;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && (b % 2 == 1)) begin
                in_valid = 1'b0;
                tick(1 + (b % 3));
            end
            in_valid = 1'b1;
            for (int j = 0; j < LANES; j++)
                in_data[32*LANES-1-32*j -: 32] = base + 32'(b*LANES + j) + 32'd1;
            t = 0;
            while (!in_ready && t < 500) begin
                tick(1);
                t++;
            end
            if (t >= 500) begin
                chk("send_ready_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int t;
        t = 0;
        while (!ExE_start && t < 300) begin
            tick(1);
            t++;
        end
        chk(tag, 64'(ExE_start), 64'd1);
    endtask

    task automatic finish_pulse();
        ExE_finish = 1'b1;
        tick(1);
        ExE_finish = 1'b0;
    endtask

    initial begin
        int s0;
        logic [NI*32-1:0] held;

        // Reset state
        tick(2);
        rst = 1'b0;
        chk("rst_inputs_zero", 64'(inputs == '0), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vec_count", 64'(vec_count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_start", 64'(ExE_start), 64'd0);

        // Single vector, words 1..64, tree idle
        send(32'd0, BEATS, 1'b0);
        chk("v1_start_not_yet", 64'(ExE_start), 64'd0);
        chk("v1_full_ready_low", 64'(in_ready), 64'd0);
        tick(1);
        chk("v1_start_pulse", 64'(ExE_start), 64'd1);
        chk("v1_first_word", 64'(inputs[2047:2016]), 64'h1);
        chk("v1_last_word", 64'(inputs[31:0]), 64'h40);
        chkv("v1_inputs", inputs, exp_vec(32'd0));
        chk("v1_busy", 64'(busy), 64'd1);
        chk("v1_vec_count", 64'(vec_count), 64'd1);
        chk("v1_ready_back", 64'(in_ready), 64'd1);
        tick(1);
        chk("v1_start_one_cycle", 64'(ExE_start), 64'd0);

        // Second vector loaded while busy, issued on finish
        send(32'd64, BEATS, 1'b0);
        chk("v2_ready_low", 64'(in_ready), 64'd0);
        s0 = starts;
        tick(4);
        chk("v2_no_start_while_busy", 64'(starts - s0), 64'd0);
        chkv("v2_inputs_held", inputs, exp_vec(32'd0));
        ExE_finish = 1'b1;
        chkv("v2_inputs_before_finish_edge", inputs, exp_vec(32'd0));
        tick(1);
        ExE_finish = 1'b0;
        chk("v2_start_after_finish", 64'(ExE_start), 64'd1);
        chkv("v2_inputs", inputs, exp_vec(32'd64));
        chk("v2_busy_stays", 64'(busy), 64'd1);
        chk("v2_vec_count", 64'(vec_count), 64'd2);
        tick(2);
        finish_pulse();
        chk("v2_busy_released", 64'(busy), 64'd0);
        chk("v2_err_clear", 64'(err), 64'd0);

        // Three vectors with input gaps, finish 10 cycles after each start
        s0 = starts;
        for (int v = 0; v < 3; v++) begin
            send(32'd128 + 32'(64*v), BEATS, 1'b1);
            wait_start("gap_start_seen");
            chkv("gap_inputs", inputs, exp_vec(32'd128 + 32'(64*v)));
            tick(10);
            finish_pulse();
        end
        tick(2);
        chk("gap_three_starts", 64'(starts - s0), 64'd3);
        chk("gap_vec_count", 64'(vec_count), 64'd5);

        // Flush after 7 beats, then a fresh vector
        s0 = starts;
        send(32'h1000, 7, 1'b0);
        in_valid = 1'b1;
        in_data = {4{32'hDEADBEEF}};
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        tick(5);
        chk("flush_no_start", 64'(starts - s0), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        send(32'h2000, BEATS, 1'b0);
        wait_start("flush_fresh_start");
        chkv("flush_fresh_inputs", inputs, exp_vec(32'h2000));
        tick(3);
        finish_pulse();
        chk("flush_one_start", 64'(starts - s0), 64'd1);

        // Finish while idle sets sticky err; rst clears everything
        finish_pulse();
        chk("err_set", 64'(err), 64'd1);
        tick(5);
        chk("err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("err_cleared_by_rst", 64'(err), 64'd0);
        chk("rst2_inputs_zero", 64'(inputs == '0), 64'd1);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_vec_count", 64'(vec_count), 64'd0);

        // rst while busy with a full buffer
        send(32'h3000, BEATS, 1'b0);
        wait_start("rstbusy_first_start");
        send(32'h4000, BEATS, 1'b0);
        chk("rstbusy_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        s0 = starts;
        chk("rstbusy_busy_clear", 64'(busy), 64'd0);
        chk("rstbusy_ready", 64'(in_ready), 64'd1);
        tick(6);
        chk("rstbusy_no_start", 64'(starts - s0), 64'd0);
        held = inputs;
        chk("rstbusy_inputs_zero", 64'(held == '0), 64'd1);
        send(32'h5000, BEATS, 1'b0);
        wait_start("rstbusy_next_start");
        chkv("rstbusy_next_inputs", inputs, exp_vec(32'h5000));
        chk("rstbusy_vec_count", 64'(vec_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
